// File: rtl/rgb_pwm_sequencer.sv
// RGB PWM sequencer: step prescaler, pattern/breathing sequencer and per-channel PWM.
// Modes: binary count, breathing fade, static duty, off. Duty reloads only at frame end.
//
// dir state | meaning
// DIR_UP    | breathing level ramps towards MAX on each step
// DIR_DOWN  | breathing level ramps towards 0; pattern advances on reaching it
module rgb_pwm_sequencer #(
    parameter int unsigned STEP_CYCLES = 48000000,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*PWM_BITS-1:0] static_duty,
    output logic [CHANNELS-1:0]          led,
    output logic [CHANNELS-1:0]          pattern,
    output logic                         step
);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_STATIC  = 2'b10,
        MODE_OFF     = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [31:0]         TC  = 32'(STEP_CYCLES - 1);
    localparam logic                POL = (ACTIVE_LOW != 0);

    logic [31:0]                        presc_q, presc_d;
    logic [PWM_BITS-1:0]                pwm_cnt_q;
    logic [PWM_BITS-1:0]                level_q, level_d;
    dir_e                               dir_q, dir_d;
    logic [CHANNELS-1:0]                pattern_q, pattern_d;
    logic [1:0]                         mode_q;
    logic                               mode_chg;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  target;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_q;
    logic [CHANNELS-1:0]                lit;
    logic [CHANNELS-1:0]                led_q;

    assign mode_chg = (mode != mode_q);
    assign step     = enable && (presc_q == TC);
    assign pattern  = pattern_q;
    assign led      = led_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            level_q   <= '0;
            dir_q     <= DIR_UP;
            pattern_q <= '0;
            mode_q    <= MODE_COUNT;
            duty_q    <= '0;
            led_q     <= {CHANNELS{POL}};
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            level_q   <= level_d;
            dir_q     <= dir_d;
            pattern_q <= pattern_d;
            mode_q    <= mode;
            if (pwm_cnt_q == MAX) begin
                duty_q <= target;
            end
            led_q     <= lit ^ {CHANNELS{POL}};
        end
    end

    // A mode change outranks a coincident step so every mode starts from a clean slate.
    always_comb begin
        presc_d   = presc_q;
        level_d   = level_q;
        dir_d     = dir_q;
        pattern_d = pattern_q;
        if (mode_chg) begin
            presc_d   = '0;
            level_d   = '0;
            dir_d     = DIR_UP;
            pattern_d = (mode == MODE_BREATHE) ? CHANNELS'(1) : '0;
        end else begin
            if (enable) begin
                presc_d = step ? '0 : presc_q + 32'd1;
            end
            if (step) begin
                case (mode)
                    MODE_COUNT: pattern_d = pattern_q + CHANNELS'(1);
                    MODE_BREATHE: begin
                        if (dir_q == DIR_UP) begin
                            if (level_q == MAX) begin
                                dir_d   = DIR_DOWN;
                                level_d = MAX - PWM_BITS'(1);
                            end else begin
                                level_d = level_q + PWM_BITS'(1);
                            end
                        end else begin
                            if (level_q == '0) begin
                                dir_d     = DIR_UP;
                                level_d   = PWM_BITS'(1);
                                pattern_d = (pattern_q == '1) ? CHANNELS'(1)
                                                              : pattern_q + CHANNELS'(1);
                            end else begin
                                level_d = level_q - PWM_BITS'(1);
                            end
                        end
                    end
                    default: pattern_d = '0;
                endcase
            end
        end
    end

    always_comb begin
        target = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode)
                MODE_COUNT:   target[c] = pattern_q[c] ? MAX : '0;
                MODE_BREATHE: target[c] = pattern_q[c] ? level_q : '0;
                MODE_STATIC:  target[c] = static_duty[c*PWM_BITS +: PWM_BITS];
                default:      target[c] = '0;
            endcase
        end
    end

    // Full-scale duty is forced lit so MAX means always on rather than 2^N-1 of 2^N.
    always_comb begin
        lit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            lit[c] = (duty_q[c] == MAX) || (pwm_cnt_q < duty_q[c]);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer (STEP_CYCLES=4, PWM_BITS=3, CHANNELS=3).
module tb_rgb_pwm_sequencer;

    logic       clk;
    logic       reset_n, rst2_n;
    logic       enable, en2;
    logic [1:0] mode, mode2;
    logic [8:0] sd, sd2;
    logic [2:0] led, led2, pattern, pattern2;
    logic       step, step2;
    logic [2:0] m_pwm;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] sd;
        int         lo0;
        int         lo1;
        int         lo2;
    } svec_t;

    svec_t tbl[4];

    rgb_pwm_sequencer #(.STEP_CYCLES(4), .PWM_BITS(3), .CHANNELS(3), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .static_duty(sd), .led(led), .pattern(pattern), .step(step)
    );

    rgb_pwm_sequencer #(.STEP_CYCLES(4), .PWM_BITS(3), .CHANNELS(3), .ACTIVE_LOW(0)) dut2 (
        .clk(clk), .reset_n(rst2_n), .enable(en2), .mode(mode2),
        .static_duty(sd2), .led(led2), .pattern(pattern2), .step(step2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame position reference, used only to place a mid-frame duty change.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_pwm <= 3'd0;
        else          m_pwm <= m_pwm + 3'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_steps(input int n);
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < 4; k++) begin
                chk("step_timing", int'(step), (k == 3) ? 1 : 0);
                tick();
            end
        end
    endtask

    task automatic count_low(input int n, output int l0, output int l1, output int l2);
        l0 = 0; l1 = 0; l2 = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (!led[0]) l0++;
            if (!led[1]) l1++;
            if (!led[2]) l2++;
        end
    endtask

    initial begin
        int l0, l1, l2, n;

        tbl[0] = '{sd: {3'd7, 3'd7, 3'd7}, lo0: 8, lo1: 8, lo2: 8};
        tbl[1] = '{sd: {3'd3, 3'd2, 3'd1}, lo0: 1, lo1: 2, lo2: 3};
        tbl[2] = '{sd: {3'd0, 3'd5, 3'd6}, lo0: 6, lo1: 5, lo2: 0};
        tbl[3] = '{sd: {3'd7, 3'd4, 3'd0}, lo0: 0, lo1: 4, lo2: 8};

        reset_n = 1'b0; rst2_n = 1'b0;
        enable = 1'b0; mode = 2'b00; sd = '0;
        en2 = 1'b1; mode2 = 2'b10; sd2 = 9'h1FF;
        repeat (3) tick();
        chk("reset_led", int'(led), 7);
        chk("reset_pattern", int'(pattern), 0);
        chk("reset_step", int'(step), 0);
        reset_n = 1'b1; rst2_n = 1'b1; enable = 1'b1;

        // COUNT: first step at cycle 3, pattern increments per step
        for (int i = 1; i <= 5; i++) begin
            run_steps(1);
            chk("count_pattern", int'(pattern), i);
        end
        tick(); tick();
        enable = 1'b0;
        chk("freeze_step", int'(step), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("freeze_step", int'(step), 0);
            chk("freeze_pattern", int'(pattern), 5);
            if (i >= 10) chk("count5_led", int'(led), 3'b010);
        end
        enable = 1'b1;
        chk("resume_step0", int'(step), 0);
        tick();
        chk("resume_step1", int'(step), 1);
        tick();
        chk("resume_pattern", int'(pattern), 6);
        run_steps(1);
        chk("count_pattern", int'(pattern), 7);
        run_steps(1);
        chk("count_wrap", int'(pattern), 0);

        // BREATHE: entered with prescaler mid-count, which must clear
        tick();
        mode = 2'b01;
        tick();
        chk("breathe_entry", int'(pattern), 1);
        run_steps(3);
        enable = 1'b0;
        repeat (10) tick();
        count_low(8, l0, l1, l2);
        chk("breathe_l3_ch0", l0, 3);
        chk("breathe_l3_ch1", l1, 0);
        chk("breathe_l3_ch2", l2, 0);
        enable = 1'b1;
        run_steps(11);
        chk("breathe_pattern_hold", int'(pattern), 1);
        run_steps(1);
        chk("breathe_advance", int'(pattern), 2);
        enable = 1'b0;
        repeat (10) tick();
        count_low(8, l0, l1, l2);
        chk("breathe_l1_ch0", l0, 0);
        chk("breathe_l1_ch1", l1, 1);
        chk("breathe_l1_ch2", l2, 0);
        enable = 1'b1;

        // BREATHE -> OFF on a step cycle
        repeat (3) tick();
        chk("off_step_cycle", int'(step), 1);
        mode = 2'b11;
        tick();
        chk("off_pattern", int'(pattern), 0);
        run_steps(1);
        chk("off_pattern_hold", int'(pattern), 0);
        repeat (10) tick();
        count_low(8, l0, l1, l2);
        chk("off_led_lit", l0 + l1 + l2, 0);

        // STATIC duty table
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            sd = tbl[i].sd;
            repeat (10) tick();
            count_low(8, l0, l1, l2);
            chk("static_ch0", l0, tbl[i].lo0);
            chk("static_ch1", l1, tbl[i].lo1);
            chk("static_ch2", l2, tbl[i].lo2);
            chk("static_pattern", int'(pattern), 0);
        end

        // mid-frame duty change waits for the frame boundary
        n = 0;
        while (m_pwm != 3'd2 && n < 16) begin
            tick();
            n++;
        end
        if (n >= 16) begin
            errors++;
            $display("FAIL frame_sync: got timeout expected pwm position 2");
        end
        sd = {3'd7, 3'd2, 3'd0};
        count_low(6, l0, l1, l2);
        chk("midframe_old_duty", l1, 2);
        count_low(8, l0, l1, l2);
        chk("midframe_new_ch1", l1, 2);
        chk("midframe_new_ch0", l0, 0);
        chk("midframe_new_ch2", l2, 8);

        // ACTIVE_LOW=0 instance: asynchronous reset while step is high
        n = 0;
        while (step2 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("al0_step_before", int'(step2), 1);
        chk("al0_led_before", int'(led2), 7);
        #2;
        rst2_n = 1'b0;
        #1;
        chk("al0_reset_led", int'(led2), 0);
        chk("al0_reset_pattern", int'(pattern2), 0);
        chk("al0_reset_step", int'(step2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
